// File: rtl/vga_pkg.sv
// Shared definitions for the VGA video-RAM arbiter.
//   VGA_ADDR_W / VGA_DATA_W : default VRAM address / pixel widths
//   R_MSB / G_MSB / B_MSB   : top bit of each colour field in an RRRGGGBB pixel
//   ST_*                    : arbiter FSM state encodings
package vga_pkg;
  localparam int VGA_ADDR_W = 15;
  localparam int VGA_DATA_W = 8;

  localparam int R_MSB = 7;
  localparam int G_MSB = 4;
  localparam int B_MSB = 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DRD  = 3'd1;
  localparam logic [2:0] ST_DCAP = 3'd2;
  localparam logic [2:0] ST_HWR  = 3'd3;
  localparam logic [2:0] ST_HRD  = 3'd4;
  localparam logic [2:0] ST_HCAP = 3'd5;
  localparam logic [2:0] ST_HACK = 3'd6;
endpackage

// File: rtl/vga_vram_arbiter_if.sv
// Host read/write port of the VRAM arbiter.
//   host_req/host_we/host_addr/host_wdata : request, held until host_ack
//   host_ack   : one-cycle completion pulse
//   host_rdata : read data, valid with host_ack, held until next read ack
// master = host side, slave = arbiter side.
interface vga_vram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata
  );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has absolute priority, host
// read/write fills idle cycles.
//   clk, reset          : 100 MHz clock, async active-high reset
//   pix_en, disp_active, disp_addr : pixel tick + visible flag + address
//   pixel_rgb           : registered RRRGGGBB pixel to the colour pins
//   underrun/underrun_clr : sticky display-overrun flag and its clear
//   host                : host port (vga_vram_arbiter_if.slave)
//   mem_addr/mem_we/mem_wdata/mem_rdata : VRAM port, 1-cycle read latency
// Build option: VRAM_BLANK_ONLY_EN restricts host grants to blanking time.
import vga_pkg::*;

module vga_vram_arbiter #(
  parameter int ADDR_W = VGA_ADDR_W,
  parameter int DATA_W = VGA_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic              disp_active,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] pixel_rgb,
  output logic              underrun,
  input  logic              underrun_clr,
  vga_vram_arbiter_if.slave host,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [2:0]        state, state_nxt;
  logic              disp_pend;
  logic [ADDR_W-1:0] disp_addr_q;
  logic              disp_take;
  logic              host_ok;
  logic [DATA_W-1:0] host_rdata_q;

  assign disp_take = pix_en & disp_active;

`ifdef VRAM_BLANK_ONLY_EN
  // Last disp_active seen on a pixel tick; host is only granted in blanking.
  logic active_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       active_q <= 1'b0;
    else if (pix_en) active_q <= disp_active;
  end
  assign host_ok = ~active_q;
`else
  assign host_ok = 1'b1;
`endif

  // IDLE also looks at the live tick so a pixel arriving together with a
  // host request wins; otherwise the host could steal the slot and push the
  // fetch past the 5-cycle bound.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (disp_pend || disp_take)        state_nxt = ST_DRD;
        else if (host.host_req && host_ok) state_nxt = host.host_we ? ST_HWR : ST_HRD;
        else                               state_nxt = ST_IDLE;
      end
      ST_DRD:  state_nxt = ST_DCAP;
      ST_DCAP: state_nxt = ST_IDLE;
      ST_HWR:  state_nxt = ST_HACK;
      ST_HRD:  state_nxt = ST_HCAP;
      ST_HCAP: state_nxt = ST_HACK;
      ST_HACK: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Pending display request. A new tick in the same cycle as the DRD clear
  // must survive, so the set is written last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_pend   <= 1'b0;
      disp_addr_q <= '0;
      underrun    <= 1'b0;
    end else begin
      if (state == ST_DRD) disp_pend <= 1'b0;
      if (disp_take) begin
        disp_addr_q <= disp_addr;
        disp_pend   <= 1'b1;
      end
      if (disp_take && disp_pend) underrun <= 1'b1;
      else if (underrun_clr)      underrun <= 1'b0;
    end
  end

  // Blanking is the newer event, so it overrides a capture in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_rgb <= '0;
    end else begin
      if (state == ST_DCAP)       pixel_rgb <= mem_rdata;
      if (pix_en && !disp_active) pixel_rgb <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 host_rdata_q <= '0;
    else if (state == ST_HCAP) host_rdata_q <= mem_rdata;
  end

  assign host.host_rdata = host_rdata_q;
  assign host.host_ack   = (state == ST_HACK);

  // Memory port decoded from state so reset drops mem_we asynchronously.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      ST_DRD: mem_addr = disp_addr_q;
      ST_HRD: mem_addr = host.host_addr;
      ST_HWR: begin
        mem_addr  = host.host_addr;
        mem_we    = 1'b1;
        mem_wdata = host.host_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
module tb_vga_vram_arbiter;
  localparam int AW = 15;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          pix_en;
  logic          disp_active;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] pixel_rgb;
  logic          underrun;
  logic          underrun_clr;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] vram [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  vga_vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) hif ();

  vga_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_en       (pix_en),
    .disp_active  (disp_active),
    .disp_addr    (disp_addr),
    .pixel_rgb    (pixel_rgb),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .host         (hif),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM, one cycle read latency.
  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    mem_rdata <= vram[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_tests++; if (pixel_rgb !== 8'h00) begin n_fail++; $display("FAIL reset_pixel got %h want 00", pixel_rgb); end
    n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got %b want 0", underrun); end
    n_tests++; if (hif.host_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", hif.host_ack); end
    n_tests++; if (hif.host_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h want 00", hif.host_rdata); end
    n_tests++; if ({mem_we, mem_addr, mem_wdata} !== 24'h0) begin n_fail++; $display("FAIL reset_mem got we=%b a=%h d=%h want 0", mem_we, mem_addr, mem_wdata); end
  endtask

  task automatic test_host_wr_rd();
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 15'h0010; hif.host_wdata = 8'hE3;
    step(); // HWR
    n_tests++; if (mem_we !== 1'b1 || mem_addr !== 15'h0010 || mem_wdata !== 8'hE3) begin n_fail++; $display("FAIL hwr_bus got we=%b a=%h d=%h want 1/0010/e3", mem_we, mem_addr, mem_wdata); end
    n_tests++; if (hif.host_ack !== 1'b0) begin n_fail++; $display("FAIL hwr_early_ack got %b want 0", hif.host_ack); end
    step(); // HACK
    n_tests++; if (hif.host_ack !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL hwr_ack got ack=%b we=%b want 1/0", hif.host_ack, mem_we); end
    hif.host_req = 1'b0;
    step(); // IDLE
    n_tests++; if (hif.host_ack !== 1'b0) begin n_fail++; $display("FAIL hwr_ack_pulse got %b want 0", hif.host_ack); end
    hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 15'h0010;
    step(); // HRD
    n_tests++; if (mem_we !== 1'b0 || mem_addr !== 15'h0010) begin n_fail++; $display("FAIL hrd_bus got we=%b a=%h want 0/0010", mem_we, mem_addr); end
    step(); // HCAP
    step(); // HACK
    n_tests++; if (hif.host_ack !== 1'b1 || hif.host_rdata !== 8'hE3) begin n_fail++; $display("FAIL hrd_ack got ack=%b d=%h want 1/e3", hif.host_ack, hif.host_rdata); end
    hif.host_req = 1'b0;
    step();
    n_tests++; if (hif.host_ack !== 1'b0 || hif.host_rdata !== 8'hE3) begin n_fail++; $display("FAIL hrd_hold got ack=%b d=%h want 0/e3", hif.host_ack, hif.host_rdata); end
  endtask

  task automatic test_display();
    logic [7:0] p;
    vram[5] = 8'h1C;
    pix_en = 1'b1; disp_active = 1'b1; disp_addr = 15'h0005;
    step(); // DRD
    pix_en = 1'b0;
    n_tests++; if (mem_addr !== 15'h0005 || mem_we !== 1'b0) begin n_fail++; $display("FAIL drd_bus got a=%h we=%b want 0005/0", mem_addr, mem_we); end
    step(); // DCAP
    step();
    p = pixel_rgb;
    n_tests++; if (p !== 8'h1C) begin n_fail++; $display("FAIL disp_pixel got %h want 1c", p); end
    n_tests++; if (p[7:5] !== 3'd0 || p[4:2] !== 3'd7 || p[1:0] !== 2'd0) begin n_fail++; $display("FAIL disp_split got r=%0d g=%0d b=%0d want 0/7/0", p[7:5], p[4:2], p[1:0]); end
    step(); step();
    n_tests++; if (pixel_rgb !== 8'h1C) begin n_fail++; $display("FAIL disp_hold got %h want 1c", pixel_rgb); end
  endtask

  task automatic test_blank();
    pix_en = 1'b1; disp_active = 1'b0; disp_addr = 15'h0005;
    step();
    pix_en = 1'b0;
    n_tests++; if (pixel_rgb !== 8'h00) begin n_fail++; $display("FAIL blank_pixel got %h want 00", pixel_rgb); end
    n_tests++; if (mem_addr !== 15'h0000) begin n_fail++; $display("FAIL blank_nofetch got a=%h want 0000", mem_addr); end
    step();
    n_tests++; if (mem_addr !== 15'h0000 || pixel_rgb !== 8'h00) begin n_fail++; $display("FAIL blank_nofetch2 got a=%h p=%h want 0000/00", mem_addr, pixel_rgb); end
  endtask

  task automatic test_priority();
    logic       exp_we [1:5];
    logic       exp_ack[1:5];
    exp_we  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_ack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vram[15'h0020] = 8'hA5;
    pix_en = 1'b1; disp_active = 1'b1; disp_addr = 15'h0020;
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 15'h0030; hif.host_wdata = 8'h5A;
    for (int c = 1; c <= 5; c++) begin
      step();
      pix_en = 1'b0;
      n_tests++; if (mem_we !== exp_we[c] || hif.host_ack !== exp_ack[c]) begin n_fail++; $display("FAIL prio_c%0d got we=%b ack=%b want %b/%b", c, mem_we, hif.host_ack, exp_we[c], exp_ack[c]); end
      if (c == 1) begin
        n_tests++; if (mem_addr !== 15'h0020) begin n_fail++; $display("FAIL prio_disp_addr got %h want 0020", mem_addr); end
      end
      if (c == 3) begin
        n_tests++; if (pixel_rgb !== 8'hA5) begin n_fail++; $display("FAIL prio_pixel got %h want a5", pixel_rgb); end
      end
      if (c == 4) begin
        n_tests++; if (mem_addr !== 15'h0030 || mem_wdata !== 8'h5A) begin n_fail++; $display("FAIL prio_wr_bus got a=%h d=%h want 0030/5a", mem_addr, mem_wdata); end
      end
    end
    hif.host_req = 1'b0;
    step();
    n_tests++; if (vram[15'h0030] !== 8'h5A) begin n_fail++; $display("FAIL prio_vram got %h want 5a", vram[15'h0030]); end
  endtask

  task automatic test_hread_then_pix();
    vram[15'h0040] = 8'h77;
    vram[15'h0050] = 8'hC3;
    hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 15'h0040;
    step(); // HRD
    pix_en = 1'b1; disp_active = 1'b1; disp_addr = 15'h0050;
    step(); // HCAP
    pix_en = 1'b0;
    step(); // HACK
    n_tests++; if (hif.host_ack !== 1'b1 || hif.host_rdata !== 8'h77) begin n_fail++; $display("FAIL hrp_ack got ack=%b d=%h want 1/77", hif.host_ack, hif.host_rdata); end
    hif.host_req = 1'b0;
    step(); // IDLE
    step(); // DRD
    n_tests++; if (mem_addr !== 15'h0050) begin n_fail++; $display("FAIL hrp_drd got a=%h want 0050", mem_addr); end
    step(); // DCAP
    n_tests++; if (pixel_rgb !== 8'hA5) begin n_fail++; $display("FAIL hrp_early got %h want a5", pixel_rgb); end
    step();
    n_tests++; if (pixel_rgb !== 8'hC3 || underrun !== 1'b0) begin n_fail++; $display("FAIL hrp_pixel got p=%h u=%b want c3/0", pixel_rgb, underrun); end
  endtask

  task automatic test_overrun();
    vram[15'h0070] = 8'h3C;
    vram[15'h0071] = 8'h99;
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 15'h0060; hif.host_wdata = 8'h11;
    step(); // HWR
    pix_en = 1'b1; disp_active = 1'b1; disp_addr = 15'h0070;
    step(); // HACK; second tick plus a clear in the same cycle
    disp_addr = 15'h0071; underrun_clr = 1'b1;
    n_tests++; if (hif.host_ack !== 1'b1 || underrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ack got ack=%b u=%b want 1/0", hif.host_ack, underrun); end
    hif.host_req = 1'b0;
    step(); // IDLE
    pix_en = 1'b0; underrun_clr = 1'b0;
    n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins got %b want 1", underrun); end
    step(); // DRD
    n_tests++; if (mem_addr !== 15'h0071) begin n_fail++; $display("FAIL ovr_addr got %h want 0071", mem_addr); end
    step(); // DCAP
    step();
    n_tests++; if (pixel_rgb !== 8'h99 || underrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pixel got p=%h u=%b want 99/1", pixel_rgb, underrun); end
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", underrun); end
  endtask

  task automatic test_reset_mid_write();
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 15'h007F; hif.host_wdata = 8'hFF;
    step(); // HWR
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_hwr got we=%b want 1", mem_we); end
    reset = 1'b1;
    #1;
    n_tests++; if (mem_we !== 1'b0 || mem_addr !== 15'h0 || mem_wdata !== 8'h0) begin n_fail++; $display("FAIL rst_async_mem got we=%b a=%h d=%h want 0", mem_we, mem_addr, mem_wdata); end
    n_tests++; if (pixel_rgb !== 8'h0 || hif.host_rdata !== 8'h0 || hif.host_ack !== 1'b0 || underrun !== 1'b0) begin n_fail++; $display("FAIL rst_async_out got p=%h r=%h ack=%b u=%b want 0", pixel_rgb, hif.host_rdata, hif.host_ack, underrun); end
    for (int c = 0; c < 2; c++) begin
      step();
      n_tests++; if (hif.host_ack !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_hold_c%0d got ack=%b we=%b want 0/0", c, hif.host_ack, mem_we); end
    end
    hif.host_req = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++; if (hif.host_ack !== 1'b0) begin n_fail++; $display("FAIL rst_noack_c%0d got %b want 0", c, hif.host_ack); end
    end
    n_tests++; if (vram[15'h007F] !== 8'h00) begin n_fail++; $display("FAIL rst_vram got %h want 00", vram[15'h007F]); end
  endtask

`ifdef VRAM_BLANK_ONLY_EN
  task automatic test_blank_only();
    pix_en = 1'b1; disp_active = 1'b1; disp_addr = 15'h0005;
    step();
    pix_en = 1'b0;
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 15'h0008; hif.host_wdata = 8'h42;
    for (int c = 0; c < 6; c++) begin
      step();
      n_tests++; if (hif.host_ack !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL bo_hold_c%0d got ack=%b we=%b want 0/0", c, hif.host_ack, mem_we); end
    end
    pix_en = 1'b1; disp_active = 1'b0;
    step(); // IDLE, grant now allowed
    pix_en = 1'b0;
    step(); // HWR
    n_tests++; if (mem_we !== 1'b1 || mem_addr !== 15'h0008) begin n_fail++; $display("FAIL bo_hwr got we=%b a=%h want 1/0008", mem_we, mem_addr); end
    step(); // HACK
    n_tests++; if (hif.host_ack !== 1'b1) begin n_fail++; $display("FAIL bo_ack got %b want 1", hif.host_ack); end
    hif.host_req = 1'b0;
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) vram[i] = 8'h00;
    reset = 1'b1; pix_en = 1'b0; disp_active = 1'b0; disp_addr = '0; underrun_clr = 1'b0;
    hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_addr = '0; hif.host_wdata = '0;
    step(); step();
    test_reset();
    reset = 1'b0;
    step();
    test_host_wr_rd();
    test_display();
    test_blank();
    test_priority();
    test_hread_then_pix();
    test_overrun();
    test_reset_mid_write();
`ifdef VRAM_BLANK_ONLY_EN
    test_blank_only();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
